// File: rtl/cas_divider_seq.sv
// cas_divider_seq: sequential 8/4 unsigned divider built on one shared
// controlled add/subtract row (non-restoring, 4 iterations + correction).
module cas_divider_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       ovf,
    output logic       div0
);

    typedef enum logic [1:0] {IDLE, ITER, CORRECT, FINISH} state_e;

    state_e     state_q, state_d;
    logic [4:0] p_q, p_d;
    logic [3:0] d_q, d_d;
    logic [3:0] q_q, q_d;
    logic [3:0] dv_q, dv_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ctl_q, ctl_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] rem_q, rem_d;
    logic       ovf_q, ovf_d;
    logic       div0_q, div0_d;

    logic [4:0] row_a, row_b, row_s;

    // Shared 5-bit row: ctl=1 subtracts the divisor, ctl=0 adds it.
    // ITER feeds the shifted partial remainder, CORRECT feeds P itself.
    always_comb begin
        row_a = {p_q[3:0], d_q[3]};
        if (state_q == CORRECT) begin
            row_a = p_q;
        end
        row_b = {1'b0, dv_q} ^ {5{ctl_q}};
        row_s = row_a + row_b + {4'b0, ctl_q};
    end

    // Next-state and datapath updates; results only move on entry to FINISH.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        q_d     = q_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dv_d = divisor;
                    if (divisor == 4'd0) begin
                        state_d = FINISH;
                        div0_d  = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = 4'hF;
                        rem_d   = 4'h0;
                    end else if (dividend[7:4] >= divisor) begin
                        state_d = FINISH;
                        div0_d  = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = 4'hF;
                        rem_d   = 4'h0;
                    end else begin
                        state_d = ITER;
                        p_d     = {1'b0, dividend[7:4]};
                        d_d     = dividend[3:0];
                        q_d     = 4'h0;
                        cnt_d   = 2'd0;
                        ctl_d   = 1'b1;
                    end
                end
            end
            ITER: begin
                p_d   = row_s;
                d_d   = {d_q[2:0], 1'b0};
                q_d   = {q_q[2:0], ~row_s[4]};
                ctl_d = ~row_s[4];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                // ctl is 0 exactly when P is negative, so the row adds back.
                if (p_q[4]) begin
                    p_d = row_s;
                end
                state_d = FINISH;
                quo_d   = q_q;
                rem_d   = p_q[4] ? row_s[3:0] : p_q[3:0];
                ovf_d   = 1'b0;
                div0_d  = 1'b0;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= 5'd0;
            d_q     <= 4'd0;
            q_q     <= 4'd0;
            dv_q    <= 4'd0;
            cnt_q   <= 2'd0;
            ctl_q   <= 1'b0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            q_q     <= q_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_cas_divider_seq.sv
// tb_cas_divider_seq: directed and randomised checks of cas_divider_seq
// against an arithmetic reference model.
module tb_cas_divider_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       ovf;
    logic       div0;

    int vecs = 0;
    int errs = 0;

    cas_divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division plus the error rules.
    task automatic model(input logic [7:0] dd, input logic [3:0] dv,
                         output logic [3:0] eq, output logic [3:0] er,
                         output logic eo, output logic ez, output int elat);
        int a, b;
        a = dd;
        b = dv;
        if (b == 0) begin
            eq = 4'hF; er = 4'h0; eo = 1'b0; ez = 1'b1; elat = 1;
        end else if (a / 16 >= b) begin
            eq = 4'hF; er = 4'h0; eo = 1'b1; ez = 1'b0; elat = 1;
        end else begin
            eq = 4'(a / b); er = 4'(a % b); eo = 1'b0; ez = 1'b0; elat = 6;
        end
    endtask

    // One division from IDLE: latency, hold of old results, busy and outputs.
    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                          input string tag);
        logic [3:0] eq, er, pq, pr;
        logic eo, ez, po, pz;
        int elat, lat;
        bit held, bsy;
        model(dd, dv, eq, er, eo, ez, elat);
        @(negedge clk);
        pq = quotient; pr = remainder; po = ovf; pz = div0;
        start = 1'b1; dividend = dd; divisor = dv;
        lat = -1; held = 1'b1; bsy = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            dividend = 8'($urandom); divisor = 4'($urandom);
            if (!busy) bsy = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (quotient !== pq || remainder !== pr || ovf !== po || div0 !== pz)
                held = 1'b0;
        end
        vecs++;
        if (lat !== elat) begin
            errs++;
            $display("FAIL %s latency dd=%h dv=%h got %0d want %0d", tag, dd, dv, lat, elat);
        end
        vecs++;
        if (!held || !bsy) begin
            errs++;
            $display("FAIL %s hold/busy dd=%h dv=%h held=%0d busy=%0d want 1 1", tag, dd, dv, held, bsy);
        end
        vecs++;
        if ({quotient, remainder, ovf, div0} !== {eq, er, eo, ez}) begin
            errs++;
            $display("FAIL %s result dd=%h dv=%h got q=%h r=%h o=%b z=%b want q=%h r=%h o=%b z=%b",
                     tag, dd, dv, quotient, remainder, ovf, div0, eq, er, eo, ez);
        end
        if (!eo && !ez) begin
            vecs++;
            if (int'(quotient) * int'(dv) + int'(remainder) != int'(dd) || remainder >= dv) begin
                errs++;
                $display("FAIL %s identity dd=%h dv=%h q=%h r=%h", tag, dd, dv, quotient, remainder);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 8'h0; divisor = 4'h0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({busy, done, quotient, remainder, ovf, div0} !== 12'h0) begin
            errs++;
            $display("FAIL reset got %b want 0", {busy, done, quotient, remainder, ovf, div0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(8'h64, 4'h7, "d64_7");
        run_op(8'h2F, 4'h5, "d2f_5");
        run_op(8'h00, 4'h1, "d00_1");
        run_op(8'h80, 4'h5, "ovf");
        run_op(8'h3C, 4'h0, "div0");
        run_op(8'hEF, 4'hF, "max");
        run_op(8'h0F, 4'h1, "ovf_edge");
    endtask

    task automatic test_start_held();
        logic [7:0] dds[10];
        logic [3:0] dvs[10];
        logic [3:0] eq, er;
        logic eo, ez;
        int elat, ndone, first;
        bit idle_seen, busy_after;
        for (int i = 0; i < 10; i++) begin
            dvs[i] = 4'($urandom_range(1, 15));
            dds[i] = {4'($urandom_range(0, int'(dvs[i]) - 1)), 4'($urandom)};
        end
        ndone = 0; first = -1; idle_seen = 1'b0; busy_after = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            if (n > 0) begin
                if (done) begin
                    ndone++;
                    if (first < 0) first = n;
                    model(dds[0], dvs[0], eq, er, eo, ez, elat);
                    vecs++;
                    if (quotient !== eq || remainder !== er) begin
                        errs++;
                        $display("FAIL held_first_ops got q=%h r=%h want q=%h r=%h",
                                 quotient, remainder, eq, er);
                    end
                end
                if (n == 7 && !busy) idle_seen = 1'b1;
                if (n == 8 && busy) busy_after = 1'b1;
            end
            start = 1'b1; dividend = dds[n]; divisor = dvs[n];
            @(negedge clk);
        end
        start = 1'b0;
        vecs++;
        if (ndone != 1 || first != 6 || !idle_seen || !busy_after) begin
            errs++;
            $display("FAIL held_start dones=%0d at=%0d idle=%0d reaccept=%0d want 1 6 1 1",
                     ndone, first, idle_seen, busy_after);
        end
        model(dds[7], dvs[7], eq, er, eo, ez, elat);
        ndone = 0;
        for (int n = 0; n < 12 && ndone == 0; n++) begin
            if (done) ndone = 1;
            else @(negedge clk);
        end
        vecs++;
        if (ndone != 1 || quotient !== eq || remainder !== er) begin
            errs++;
            $display("FAIL held_second done=%0d got q=%h r=%h want q=%h r=%h",
                     ndone, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        start = 1'b1; dividend = 8'h64; divisor = 4'h7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({busy, done, quotient, remainder, ovf, div0} !== 12'h0) begin
            errs++;
            $display("FAIL reset_mid outputs got %b want 0",
                     {busy, done, quotient, remainder, ovf, div0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        vecs++;
        if (ndone != 0) begin
            errs++;
            $display("FAIL reset_mid_abort got %0d active cycles want 0", ndone);
        end
        run_op(8'h64, 4'h7, "after_rst");
    endtask

    task automatic test_random();
        logic [7:0] dd;
        logic [3:0] dv;
        for (int i = 0; i < 400; i++) begin
            dd = 8'($urandom);
            dv = 4'($urandom);
            run_op(dd, dv, "rand");
        end
    endtask

    task automatic test_sweep();
        for (int v = 1; v < 16; v++) begin
            for (int h = 0; h < v; h++) begin
                for (int l = 0; l < 16; l++) begin
                    run_op(8'(h * 16 + l), 4'(v), "sweep");
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
